reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter WIDTH, default 32, data width of each architectural register.
REQ-002 Parameter NREG, default 32, register count; power of two, >= 2; index 0 hardwired zero.
REQ-003 Parameter PEND_W, default 2, width of per-register pending-write counter (max 2^PEND_W-1 in-flight writes).
REQ-004 AW = log2(NREG), derived, not overridable.
REQ-005 Ports SHALL be:
 clk  in  1  single clock, rising edge.
 reset  in  1  synchronous, active-high.
 halt  in  1  freeze: blocks all state updates; reads stay live.
 rs1_sel  in  AW  read port 1 index.
 rs2_sel  in  AW  read port 2 index.
 rs1  out  WIDTH  read port 1 data, combinational.
 rs2  out  WIDTH  read port 2 data, combinational.
 rs1_busy  out  1  rs1_sel has an outstanding write not satisfied this cycle.
 rs2_busy  out  1  same for rs2_sel.
 iss_en  in  1  issue request: reserve one pending write to iss_sel.
 iss_sel  in  AW  issue target index.
 iss_ready  out  1  issue will be accepted this cycle.
 w_en  in  1  write-back valid.
 w_sel  in  AW  write-back index.
 w_data  in  WIDTH  write-back data.
 dbg_sel  in  AW  debug read index.
 dbg_data  out  WIDTH  registered debug read data.
 idle  out  1  no pending writes on any register.
 sb_err  out  1  sticky scoreboard underflow flag.

Function
REQ-006 Write effective (weff) = w_en & !halt & !reset & w_sel != 0; on weff, reg[w_sel] <= w_data at the rising edge.
REQ-007 Register 0 SHALL read 0 always; writes and issues to index 0 SHALL be ignored with no counter or error effect.
REQ-008 rsN = 0 if rsN_sel==0; else w_data if weff & w_sel==rsN_sel (bypass); else reg[rsN_sel].
REQ-009 Bypass SHALL NOT apply while halt or reset is high.
REQ-010 Per-register counter pend[r], PEND_W bits; issue accepted (iacc) = iss_en & iss_ready & !halt & iss_sel != 0.
REQ-011 iss_ready = !halt & (pend[iss_sel] != max | (weff & w_sel==iss_sel)); for iss_sel==0, iss_ready = !halt.
REQ-012 Next pend[r]: +1 on iacc only, -1 on weff only (if pend[r]>0), unchanged on both same cycle or neither.
REQ-013 weff with pend[w_sel]==0: data still written, counter stays 0, sb_err <= 1 (sticky until reset).
REQ-014 rsN_busy = rsN_sel != 0 & (pend[rsN_sel] - (weff & w_sel==rsN_sel)) != 0; issue in same cycle SHALL NOT affect busy.
REQ-015 idle = all pend[r]==0, from registered state only.
REQ-016 dbg_data <= reg[dbg_sel] each edge (0 for index 0), no bypass, 1-cycle latency; updates even during halt.
REQ-017 halt SHALL freeze reg array, pend, sb_err; rs1/rs2 reflect stored values only.

Reset
REQ-018 While reset high at an edge: all registers 0, all pend 0, sb_err 0, dbg_data 0; w_en/iss_en ignored.
REQ-019 Reset asserted mid-operation SHALL discard all pending reservations in one cycle; idle=1 and rs1/rs2=0 the cycle after.
REQ-020 Reset SHALL take priority over halt.

Verification
REQ-021 Reset, then rs1_sel=5, rs2_sel=0 -> rs1=0, rs2=0, idle=1, sb_err=0, iss_ready=1.
REQ-022 w_en=1, w_sel=7, w_data=0xDEADBEEF, rs1_sel=7 same cycle -> rs1=0xDEADBEEF combinationally; next cycle dbg_sel=7 -> dbg_data=0xDEADBEEF one cycle later.
REQ-023 Issue to r3 three times (PEND_W=2) -> pend=3, iss_ready=0 for iss_sel=3; fourth issue with concurrent w_sel=3 write accepted, pend stays 3; rs1_sel=3 busy=1.
REQ-024 Issue r4 once, then w_en w_sel=4 data 0x12 with rs2_sel=4 -> rs2_busy=0 and rs2=0x12 that cycle; idle=1 next cycle.
REQ-025 halt=1 with w_en w_sel=9 data 0x55 and iss_en r9 -> reg[9], pend[9] unchanged, rs1(sel 9) shows old value, iss_ready=0.
REQ-026 w_en w_sel=10 with pend[10]=0 -> reg[10] written, sb_err=1 next cycle and stays 1 until reset; write/issue to r0 -> rs1(sel 0)=0, no sb_err.

Source files
------------

// File: rtl/reg_file_sb.sv
// Architectural register file with per-register pending-write scoreboard,
// write-back bypass on both read ports and a registered debug read port.
module reg_file_sb #(
  parameter  int WIDTH  = 32,
  parameter  int NREG   = 32,
  parameter  int PEND_W = 2,
  localparam int AW     = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [AW-1:0]    rs1_sel,
  input  logic [AW-1:0]    rs2_sel,
  output logic [WIDTH-1:0] rs1,
  output logic [WIDTH-1:0] rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_sel,
  output logic             iss_ready,
  input  logic             w_en,
  input  logic [AW-1:0]    w_sel,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic             idle,
  output logic             sb_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [WIDTH-1:0]  r_regs      [NREG];
  logic [PEND_W-1:0] r_pend      [NREG];
  logic [PEND_W-1:0] w_pend_next [NREG];
  logic              r_sb_err;
  logic [WIDTH-1:0]  r_dbg_data;

  logic            w_weff;
  logic            w_iacc;
  logic            w_underflow;
  logic            w_rs1_hit;
  logic            w_rs2_hit;
  logic            w_iss_hit;
  logic            w_idle;
  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;

  // Effective write: halt and reset both suppress state change and bypass.
  assign w_weff      = w_en & ~halt & ~reset & (w_sel != '0);
  assign w_underflow = w_weff & (r_pend[w_sel] == '0);

  assign w_rs1_hit = w_weff & (w_sel == rs1_sel);
  assign w_rs2_hit = w_weff & (w_sel == rs2_sel);
  assign w_iss_hit = w_weff & (w_sel == iss_sel);

  assign rs1 = (rs1_sel == '0) ? '0 : (w_rs1_hit ? w_data : r_regs[rs1_sel]);
  assign rs2 = (rs2_sel == '0) ? '0 : (w_rs2_hit ? w_data : r_regs[rs2_sel]);

  // A matching write-back retires one reservation; an empty counter stays not-busy.
  assign rs1_busy = (rs1_sel != '0) && (r_pend[rs1_sel] != '0) &&
                    !((r_pend[rs1_sel] == PEND_ONE) && w_rs1_hit);
  assign rs2_busy = (rs2_sel != '0) && (r_pend[rs2_sel] != '0) &&
                    !((r_pend[rs2_sel] == PEND_ONE) && w_rs2_hit);

  assign iss_ready = (iss_sel == '0) ? ~halt
                   : (~halt & ((r_pend[iss_sel] != PEND_MAX) | w_iss_hit));
  assign w_iacc    = iss_en & iss_ready & ~halt & (iss_sel != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_decode
      assign w_inc[gi] = w_iacc & (iss_sel == AW'(gi));
      assign w_dec[gi] = w_weff & (w_sel == AW'(gi));
    end
  endgenerate

  // Issue and retire to the same register in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_pend_next[i] = r_pend[i];
      if (w_inc[i] && !w_dec[i]) begin
        w_pend_next[i] = r_pend[i] + PEND_ONE;
      end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
        w_pend_next[i] = r_pend[i] - PEND_ONE;
      end
    end
  end

  always_comb begin
    w_idle = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (r_pend[i] != '0) begin
        w_idle = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_sb_err   <= 1'b0;
      r_dbg_data <= '0;
    end else begin
      // Debug port keeps sampling while halted.
      r_dbg_data <= (dbg_sel == '0) ? '0 : r_regs[dbg_sel];
      if (!halt) begin
        for (int i = 0; i < NREG; i++) begin
          r_pend[i] <= w_pend_next[i];
        end
        if (w_weff) begin
          r_regs[w_sel] <= w_data;
        end
        if (w_underflow) begin
          r_sb_err <= 1'b1;
        end
      end
    end
  end

  assign dbg_data = r_dbg_data;
  assign idle     = w_idle;
  assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised scoreboard bench for reg_file_sb: stimulus pushes expected
// outputs from an array-based model, a negedge monitor pops and compares.
module tb_reg_file_sb;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int PMAX  = 3;

  logic        clk = 1'b0;
  logic        reset, halt;
  logic [4:0]  rs1_sel, rs2_sel, iss_sel, w_sel, dbg_sel;
  logic [31:0] rs1, rs2, w_data, dbg_data;
  logic        rs1_busy, rs2_busy, iss_en, iss_ready, w_en, idle, sb_err;

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(WIDTH), .NREG(NREG), .PEND_W(2)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_en(iss_en), .iss_sel(iss_sel), .iss_ready(iss_ready),
    .w_en(w_en), .w_sel(w_sel), .w_data(w_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .idle(idle), .sb_err(sb_err)
  );

  typedef struct {
    int          id;
    logic [31:0] rs1, rs2, dbg;
    logic        b1, b2, rdy, idl, err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;
  bit   mon_en = 0;

  // Reference model state
  logic [31:0] m_regs [NREG];
  int          m_pend [NREG];
  logic        m_err;
  logic [31:0] m_dbg;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL txn=%0d %s got=%h want=%h", id, name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL queue_empty got=0 entries want>=1");
        end else begin
          e = q.pop_front();
          chk("rs1",       e.id, rs1,       e.rs1);
          chk("rs2",       e.id, rs2,       e.rs2);
          chk("rs1_busy",  e.id, 32'(rs1_busy),  32'(e.b1));
          chk("rs2_busy",  e.id, 32'(rs2_busy),  32'(e.b2));
          chk("iss_ready", e.id, 32'(iss_ready), 32'(e.rdy));
          chk("idle",      e.id, 32'(idle),      32'(e.idl));
          chk("sb_err",    e.id, 32'(sb_err),    32'(e.err));
          chk("dbg_data",  e.id, dbg_data,  e.dbg);
          $display("txn %0d rs1=%h rs2=%h b=%b%b rdy=%b idle=%b err=%b dbg=%h",
                   e.id, rs1, rs2, rs1_busy, rs2_busy, iss_ready, idle, sb_err, dbg_data);
        end
      end
    end
  end

  function automatic logic [31:0] rd(input int sel, input bit weff, input int ws, input logic [31:0] wd);
    if (sel == 0) return 32'h0;
    if (weff && ws == sel) return wd;
    return m_regs[sel];
  endfunction

  task automatic step(input bit rst, input bit hlt, input bit ien, input int isel,
                      input bit wen, input int wsel, input logic [31:0] wd,
                      input int s1, input int s2, input int ds);
    exp_t e;
    bit   weff, rdy, iacc, idl;
    reset = rst; halt = hlt; iss_en = ien; iss_sel = 5'(isel);
    w_en = wen; w_sel = 5'(wsel); w_data = wd;
    rs1_sel = 5'(s1); rs2_sel = 5'(s2); dbg_sel = 5'(ds);

    weff = wen && !hlt && !rst && wsel != 0;
    rdy  = (isel == 0) ? !hlt : (!hlt && (m_pend[isel] < PMAX || (weff && wsel == isel)));
    idl  = 1'b1;
    for (int r = 0; r < NREG; r++) if (m_pend[r] != 0) idl = 1'b0;

    e.id  = txn++;
    e.rs1 = rd(s1, weff, wsel, wd);
    e.rs2 = rd(s2, weff, wsel, wd);
    e.b1  = (s1 != 0) && (m_pend[s1] > ((weff && wsel == s1) ? 1 : 0));
    e.b2  = (s2 != 0) && (m_pend[s2] > ((weff && wsel == s2) ? 1 : 0));
    e.rdy = rdy;
    e.idl = idl;
    e.err = m_err;
    e.dbg = m_dbg;
    q.push_back(e);

    // Advance the model to the state after the coming edge.
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
      m_err = 0;
      m_dbg = 0;
    end else begin
      m_dbg = (ds == 0) ? 32'h0 : m_regs[ds];
      if (!hlt) begin
        iacc = ien && rdy && isel != 0;
        if (weff && m_pend[wsel] == 0) m_err = 1;
        if (iacc && !(weff && wsel == isel)) m_pend[isel]++;
        if (weff && !(iacc && wsel == isel) && m_pend[wsel] > 0) m_pend[wsel]--;
        if (weff) m_regs[wsel] = wd;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic int pick_sel();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
    return int'($urandom_range(0, 7));
  endfunction

  function automatic int pick_wsel();
    int cand[$];
    for (int r = 1; r < NREG; r++) if (m_pend[r] != 0) cand.push_back(r);
    if (cand.size() != 0 && $urandom_range(0, 3) != 0)
      return cand[$urandom_range(0, cand.size() - 1)];
    return pick_sel();
  endfunction

  initial begin
    reset = 1; halt = 0; iss_en = 0; iss_sel = 0; w_en = 0; w_sel = 0;
    w_data = 0; rs1_sel = 0; rs2_sel = 0; dbg_sel = 0;
    for (int r = 0; r < NREG; r++) begin m_regs[r] = 0; m_pend[r] = 0; end
    m_err = 0; m_dbg = 0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;

    // reset state
    step(0,0,0,0, 0,0,32'h0, 5,0,0);
    // bypass and debug latency
    step(0,0,0,0, 1,7,32'hDEADBEEF, 7,0,0);
    step(0,0,0,0, 0,0,32'h0, 7,0,7);
    step(0,0,0,0, 0,0,32'h0, 0,0,0);
    step(1,0,0,0, 0,0,32'h0, 0,0,0);
    // saturate r3, then issue with concurrent retire
    repeat (3) step(0,0,1,3, 0,0,32'h0, 3,0,0);
    step(0,0,1,3, 1,3,32'h33, 3,0,0);
    step(0,0,1,3, 0,0,32'h0, 3,0,0);
    // single reservation on r4 retired
    step(0,0,1,4, 0,0,32'h0, 0,4,0);
    step(0,0,0,0, 1,4,32'h12, 0,4,0);
    repeat (3) step(0,0,0,0, 1,3,32'h3300, 3,4,4);
    step(0,0,0,0, 0,0,32'h0, 3,4,3);
    // halt freezes writes and issues
    step(0,0,1,9, 0,0,32'h0, 9,0,0);
    step(0,1,1,9, 1,9,32'h55, 9,0,9);
    step(0,0,0,0, 0,0,32'h0, 9,0,9);
    // underflow and index 0
    step(0,0,1,0, 1,0,32'hFF, 0,0,0);
    step(0,0,0,0, 1,10,32'hA5, 10,0,0);
    step(0,0,0,0, 1,9,32'h66, 9,10,10);
    // reset discards reservations; reset beats halt
    step(0,0,1,5, 0,0,32'h0, 5,0,0);
    step(1,1,1,6, 1,5,32'h77, 5,6,5);
    step(0,0,0,0, 0,0,32'h0, 5,6,5);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, pick_sel(),
           $urandom_range(0, 1) == 1, pick_wsel(), $urandom,
           pick_sel(), pick_sel(), pick_sel());
    end

    mon_en = 0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d entries want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
